// File: rtl/fft_twiddle_seq_pkg.sv
// Shared widths, FSM encoding and quarter-wave cosine table for the
// twiddle sequencer.
package fft_twiddle_seq_pkg;

   localparam int N    = 32;
   localparam int W_W  = 9;
   localparam int FRAC = 8;
   localparam int KW   = $clog2(N / 4);
   localparam int MW   = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic          valid;
      logic          last;
      logic          conj;
      logic [KW-1:0] idx;
      logic [MW-1:0] m2;
      logic [MW-1:0] m3;
      logic [MW-1:0] m4;
   } s1_t;

   typedef struct packed {
      logic           valid;
      logic           last;
      logic [KW-1:0]  idx;
      logic [W_W-1:0] wr2;
      logic [W_W-1:0] wi2;
      logic [W_W-1:0] wr3;
      logic [W_W-1:0] wi3;
      logic [W_W-1:0] wr4;
      logic [W_W-1:0] wi4;
   } s2_t;

   // round(cos(2*pi*r/N) * 2^FRAC), 1.0 clipped to 2^FRAC-1
   function automatic logic [W_W-1:0] c_lut(input logic [KW:0] r);
      logic [W_W-1:0] v;
      v = '0;
      case (r)
         4'd0: v = W_W'(255);
         4'd1: v = W_W'(251);
         4'd2: v = W_W'(237);
         4'd3: v = W_W'(213);
         4'd4: v = W_W'(181);
         4'd5: v = W_W'(142);
         4'd6: v = W_W'(98);
         4'd7: v = W_W'(50);
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/fft_twiddle_seq_fold_lut.sv
// Exponent m -> (cos, -sin) via quarter-wave table and quadrant fold;
// conj flips the imaginary sign for inverse transforms.
module twiddle_fold_lut
   import fft_twiddle_seq_pkg::*;
(
   input  logic [MW-1:0]  m,
   input  logic           conj,
   output logic [W_W-1:0] w_real,
   output logic [W_W-1:0] w_imag
);

   logic [1:0]     q;
   logic [KW:0]    r;
   logic [KW:0]    rc;
   logic [W_W-1:0] c_r;
   logic [W_W-1:0] c_rc;
   logic [W_W-1:0] cos_v;
   logic [W_W-1:0] sin_v;

   assign q    = m[MW-1:KW];
   assign r    = {1'b0, m[KW-1:0]};
   assign rc   = (KW+1)'(N / 4) - r;
   assign c_r  = c_lut(r);
   assign c_rc = c_lut(rc);

   always_comb begin
      cos_v = c_r;
      sin_v = c_rc;
      unique case (q)
         2'd0: begin cos_v = c_r;   sin_v = c_rc;  end
         2'd1: begin cos_v = -c_rc; sin_v = c_r;   end
         2'd2: begin cos_v = -c_r;  sin_v = -c_rc; end
         2'd3: begin cos_v = c_rc;  sin_v = -c_r;  end
         default: ;
      endcase
   end

   assign w_real = cos_v;
   assign w_imag = conj ? sin_v : -sin_v;

endmodule

// File: rtl/fft_twiddle_seq.sv
// Twiddle sequencer: emits W^k, W^2k, W^3k for k = 0..N/4-1 after start.
// FFT_TWIDDLE_INVERSE_EN adds an inverse input for conjugate twiddles.
module fft_twiddle_seq
   import fft_twiddle_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  ready,
`ifdef FFT_TWIDDLE_INVERSE_EN
   input  logic                  inverse,
`endif
   output logic signed [W_W-1:0] w_real_2,
   output logic signed [W_W-1:0] w_imag_2,
   output logic signed [W_W-1:0] w_real_3,
   output logic signed [W_W-1:0] w_imag_3,
   output logic signed [W_W-1:0] w_real_4,
   output logic signed [W_W-1:0] w_imag_4,
   output logic                  w_valid,
   output logic                  w_last,
   output logic [KW-1:0]         w_index,
   output logic                  busy
);

   state_t         state_q, state_d;
   logic [KW-1:0]  k_q, k_d;
   logic           inv_q, inv_d;
   logic           busy_q, busy_d;
   s1_t            s1_q, s1_d;
   s2_t            s2_q, s2_d;
   logic           issue;
   logic [MW-1:0]  k_ext;
   logic [W_W-1:0] f_wr2, f_wi2, f_wr3, f_wi3, f_wr4, f_wi4;

   twiddle_fold_lut u_lut2 (.m(s1_q.m2), .conj(s1_q.conj),
                            .w_real(f_wr2), .w_imag(f_wi2));
   twiddle_fold_lut u_lut3 (.m(s1_q.m3), .conj(s1_q.conj),
                            .w_real(f_wr3), .w_imag(f_wi3));
   twiddle_fold_lut u_lut4 (.m(s1_q.m4), .conj(s1_q.conj),
                            .w_real(f_wr4), .w_imag(f_wi4));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      inv_d   = inv_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      issue   = 1'b0;
      k_ext   = MW'(k_q);
      // k=0 issues in the start cycle itself to get 2-cycle latency
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
`ifdef FFT_TWIDDLE_INVERSE_EN
               inv_d   = inverse;
`else
               inv_d   = 1'b0;
`endif
               k_ext   = '0;
               issue   = ready;
               k_d     = ready ? KW'(1) : '0;
            end
         end
         RUN: begin
            if (ready) begin
               issue = 1'b1;
               k_d   = k_q + KW'(1);
               if (k_q == KW'(N / 4 - 1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (ready && s2_q.valid && s2_q.last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (ready) begin
         s1_d.valid = issue;
         if (issue) begin
            s1_d.last = (k_ext == MW'(N / 4 - 1));
            s1_d.conj = inv_d;
            s1_d.idx  = k_ext[KW-1:0];
            s1_d.m2   = k_ext;
            s1_d.m3   = k_ext << 1;
            s1_d.m4   = k_ext + (k_ext << 1);
         end
         s2_d.valid = s1_q.valid;
         s2_d.last  = s1_q.valid & s1_q.last;
         if (s1_q.valid) begin
            s2_d.idx = s1_q.idx;
            s2_d.wr2 = f_wr2;
            s2_d.wi2 = f_wi2;
            s2_d.wr3 = f_wr3;
            s2_d.wi3 = f_wi3;
            s2_d.wr4 = f_wr4;
            s2_d.wi4 = f_wi4;
         end
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         inv_q   <= 1'b0;
         busy_q  <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         inv_q   <= inv_d;
         busy_q  <= busy_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
      end
   end

   assign w_real_2 = s2_q.wr2;
   assign w_imag_2 = s2_q.wi2;
   assign w_real_3 = s2_q.wr3;
   assign w_imag_3 = s2_q.wi3;
   assign w_real_4 = s2_q.wr4;
   assign w_imag_4 = s2_q.wi4;
   assign w_valid  = s2_q.valid;
   assign w_last   = s2_q.last;
   assign w_index  = s2_q.idx;
   assign busy     = busy_q;

endmodule

// File: tb/tb_fft_twiddle_seq.sv
// Directed bench for fft_twiddle_seq with hand-computed twiddle values.
module tb_fft_twiddle_seq;

   logic              clk;
   logic              rst;
   logic              start;
   logic              ready;
`ifdef FFT_TWIDDLE_INVERSE_EN
   logic              inverse;
`endif
   logic signed [8:0] w_real_2, w_imag_2;
   logic signed [8:0] w_real_3, w_imag_3;
   logic signed [8:0] w_real_4, w_imag_4;
   logic              w_valid, w_last, busy;
   logic [2:0]        w_index;

   int checks = 0;
   int errors = 0;

   fft_twiddle_seq dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready),
`ifdef FFT_TWIDDLE_INVERSE_EN
      .inverse(inverse),
`endif
      .w_real_2(w_real_2), .w_imag_2(w_imag_2),
      .w_real_3(w_real_3), .w_imag_3(w_imag_3),
      .w_real_4(w_real_4), .w_imag_4(w_imag_4),
      .w_valid(w_valid), .w_last(w_last),
      .w_index(w_index), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic chk_set(input string tag, input int r2, input int i2,
                          input int r3, input int i3,
                          input int r4, input int i4);
      check({tag, "_r2"}, w_real_2, r2);
      check({tag, "_i2"}, w_imag_2, i2);
      check({tag, "_r3"}, w_real_3, r3);
      check({tag, "_i3"}, w_imag_3, i3);
      check({tag, "_r4"}, w_real_4, r4);
      check({tag, "_i4"}, w_imag_4, i4);
   endtask

   // tick until the w_last set, count valid sets, then wait for idle
   task automatic finish_seq(input int seen, input string tag);
      int n = seen;
      int t = 0;
      while (!(w_valid && w_last) && t < 40) begin
         tick();
         t++;
         if (w_valid) n++;
      end
      check({tag, "_len"}, n, 8);
      check({tag, "_lastidx"}, w_index, 7);
      t = 0;
      while (busy && t < 20) begin
         tick();
         t++;
      end
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      ready = 1'b1;
`ifdef FFT_TWIDDLE_INVERSE_EN
      inverse = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid", w_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_r2", w_real_2, 0);

      // basic sequence
      start = 1'b1;
      tick();
      start = 1'b0;
      check("lat_valid0", w_valid, 0);
      check("lat_busy", busy, 1);
      tick();
      check("lat_valid1", w_valid, 1);
      chk_set("k0", 255, 0, 255, 0, 255, 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("seq_idx%0d", i), w_index, i);
         check($sformatf("seq_valid%0d", i), w_valid, 1);
         check($sformatf("seq_last%0d", i), w_last, (i == 7) ? 1 : 0);
         if (i == 2) chk_set("k2", 237, -98, 181, -181, 98, -237);
         if (i == 7) chk_set("k7", 50, -251, -237, -98, -142, 213);
         tick();
      end
      check("end_valid", w_valid, 0);
      check("end_busy", busy, 0);
      check("end_hold_r2", w_real_2, 50);

      // stall on k=3
      launch();
      for (int i = 0; i < 3; i++) tick();
      check("pre_stall_idx", w_index, 3);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_idx", w_index, 3);
         check("stall_valid", w_valid, 1);
         check("stall_r2", w_real_2, 213);
         check("stall_i2", w_imag_2, -142);
      end
      ready = 1'b1;
      tick();
      check("post_stall_idx", w_index, 4);
      finish_seq(5, "stall");

      // start during RUN is ignored
      launch();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_start_idx", w_index, 2);
      finish_seq(3, "runstart");

      // relaunch, then reset at k=5
      launch();
      check("relaunch_idx", w_index, 0);
      check("relaunch_valid", w_valid, 1);
      for (int i = 0; i < 5; i++) tick();
      check("pre_rst_idx", w_index, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", w_valid, 0);
      check("mid_rst_busy", busy, 0);
      chk_set("mid_rst", 0, 0, 0, 0, 0, 0);
      launch();
      check("after_rst_idx", w_index, 0);
      chk_set("after_rst", 255, 0, 255, 0, 255, 0);
      finish_seq(1, "after_rst");

`ifdef FFT_TWIDDLE_INVERSE_EN
      inverse = 1'b1;
      launch();
      inverse = 1'b0;
      tick();
      tick();
      check("inv_idx", w_index, 2);
      chk_set("inv_k2", 237, 98, 181, 181, 98, 237);
      finish_seq(3, "inv");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_twiddle_seq.md
Name: fft_twiddle_seq

Overview:
- Twiddle-factor sequencer that drives the W_real_2..4 / W_imag_2..4 inputs of the 2x2 twiddle multiplier stage in the 32-point parallel 2D FFT.
- On a start pulse it emits N/4 consecutive twiddle sets for radix-2^2 kernel index k = 0..N/4-1:
  - W2 = W_N^k
  - W3 = W_N^(2k)
  - W4 = W_N^(3k)
- Coefficients come from a quarter-wave cosine LUT with quadrant folding.
- Backpressure is a single ready input that freezes the whole pipeline.

Parameters:
- N, 32, transform length; power of two, >= 8.
- W_W, 9, signed twiddle width; matches the multiplier's WBus.
- FRAC, 8, fractional bits; 1.0 saturates to 2^FRAC-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle launch request; accepted only in IDLE.
- ready  in  1  downstream accepts; 0 freezes pipeline and counter.
- w_real_2, w_imag_2  out  W_W each  W_N^k (signed).
- w_real_3, w_imag_3  out  W_W each  W_N^(2k).
- w_real_4, w_imag_4  out  W_W each  W_N^(3k).
- w_valid  out  1  twiddle outputs are valid.
- w_last  out  1  high together with w_valid for k = N/4-1.
- w_index  out  log2(N/4)  k of the presented set; used for alignment against the 2-cycle multiplier latency.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset is synchronous, active-high. On reset:
  - all outputs go to 0 and the FSM goes to IDLE.
  - k and the pipeline valid bits clear.
  - Reset mid-sequence aborts immediately; there is no drain.
- FSM states:
  - IDLE: start=1 moves to RUN with k=0.
  - RUN: each cycle with ready=1 issues k into stage 1 and increments k. When k = N/4-1 is issued, move to DRAIN.
  - DRAIN: waits until the last set has left stage 2 with ready=1, then returns to IDLE.
- start is ignored outside IDLE. Simultaneous rst and start: rst wins.
- Pipeline:
  - Stage 1 registers the three exponents m2=k, m3=2k, m4=3k, each mod N, plus a valid bit.
  - Stage 2 registers the folded LUT results, valid, last and index.
  - Latency: with ready held high, the first w_valid appears 2 cycles after the cycle in which start was sampled in IDLE.
  - Sets then follow on consecutive cycles; a full sequence occupies N/4 valid cycles.
- ready=0:
  - every register holds its value, including k, the stage registers and the outputs.
  - w_valid stays as it was; no set is lost or duplicated.
- Arithmetic, with theta = 2*pi*m/N:
  - W_real = round(cos(theta) * 2^FRAC)
  - W_imag = -round(sin(theta) * 2^FRAC)
  - Magnitude 2^FRAC saturates to 2^FRAC-1. Negated values are symmetric (-255, never -256).
- LUT and folding:
  - LUT C[r], r = 0..N/4. For N=32: 255, 251, 237, 213, 181, 142, 98, 50, 0.
  - Q = m >> log2(N/4), r = m mod N/4.
  - Q0: cos = C[r], sin = C[N/4-r]
  - Q1: cos = -C[N/4-r], sin = C[r]
  - Q2: cos = -C[r], sin = -C[N/4-r]
  - Q3: cos = C[N/4-r], sin = -C[r]
- 3k wraps modulo N; the maximum exponent for N=32 is 21.
- When w_valid=0, the twiddle outputs keep their last value; they are not zeroed.

Optional Feature:
- Macro: FFT_TWIDDLE_INVERSE_EN.
- Defined:
  - adds input port inverse (1 bit).
  - inverse is sampled when start is accepted and held for the whole sequence.
  - When latched 1, all W_imag outputs are negated (conjugate twiddles for the IFFT). W_real is unchanged.
- Undefined:
  - no inverse port.
  - behaviour is forward-FFT only, as above.

Decomposition:
- Shared package holds:
  - N, W_W, FRAC and the derived widths log2(N/4) and log2(N).
  - FSM state encoding (IDLE, RUN, DRAIN).
  - The N=32 quarter-wave constant table.
- Sub-module twiddle_fold_lut:
  - combinational LUT plus quadrant fold, mapping m to (w_real, w_imag).
  - instantiated three times (m2, m3, m4) between stage 1 and stage 2.

Test Plan:
- Reset, then start=1 for one cycle with ready=1:
  - w_valid rises 2 cycles later.
  - k=0 gives all three sets = (255, 0).
  - w_index counts 0..7.
  - w_last is high only on the 8th set.
  - busy falls after drain.
- Value check:
  - k=2: W2=(237,-98), W3=(181,-181), W4=(98,-237).
  - k=7: W2=(50,-251), W3=(-237,-98), W4=(-142,213).
- Stall: ready=0 for 3 cycles while the k=3 set is presented:
  - outputs and w_index=3 hold.
  - k=4 appears the cycle after ready returns to 1.
  - the sequence stays 8 sets long.
- start pulsed during RUN is ignored (no restart, still 8 sets). A new start in IDLE relaunches from k=0.
- rst asserted at k=5 mid-sequence:
  - next cycle w_valid=0, busy=0, all twiddle outputs 0.
  - a subsequent start begins again at k=0.
- With FFT_TWIDDLE_INVERSE_EN, inverse=1 at start:
  - k=2 gives W2=(237,98) and W4=(98,237).
  - toggling inverse mid-sequence has no effect.
